clk_en_synth: RTL and testbench

- Parametrised, multi-channel clock-enable synthesiser. Successor to the fixed two-output PLL wrapper.
- Runs entirely in the fast system clock domain, driven by the PLL's 120 MHz output.
- Each channel produces a single-cycle enable pulse at a fractional rate NUM/DEN of the input clock, for example a 12 MHz CPU enable and a pixel enable.
- Rates are reconfigurable at runtime. A locked flag mimics PLL lock semantics, so downstream logic keeps its existing reset gating.

---
 rtl/clk_en_synth.sv | 118 +++++++++++
 tb/tb_clk_en_synth.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_synth.sv
// Multi-channel fractional clock-enable synthesiser (rate = refclk * num / DEN).
// A lock sequence gates all channels so they start accumulating together after reset or reconfiguration.
module clk_en_synth #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned DEN = 120,
  parameter logic [CHANNELS*ACC_W-1:0] NUM_INIT = {16'd12, 16'd12},
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]    cfg_num,
  output logic [CHANNELS-1:0] outclk_en,
  output logic                locked
);

  localparam logic [1:0] ST_LOCKING = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RECONF  = 2'd2;

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [ACC_W-1:0] DEN_N = ACC_W'(DEN);
  localparam logic [ACC_W:0]   DEN_W = (ACC_W+1)'(DEN);

  logic [1:0]          state;
  logic [CNT_W-1:0]    lock_cnt;
  logic [ACC_W-1:0]    num [CHANNELS];
  logic [ACC_W-1:0]    acc [CHANNELS];
  logic [CHANNELS-1:0] en_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [ACC_W-1:0]    num_q;

  logic [ACC_W:0]      sum     [CHANNELS];
  logic [ACC_W-1:0]    acc_nxt [CHANNELS];
  logic [CHANNELS-1:0] en_nxt;
  logic                take;
  logic                chan_ok;

  assign cfg_ready = (state == ST_RUN);
  assign locked    = (state == ST_RUN);
  assign outclk_en = en_q;
  assign take      = cfg_valid && cfg_ready;
  assign chan_ok   = (32'(cfg_chan) < CHANNELS);

  // Numerators above DEN saturate to DEN, so the accumulator always stays below DEN.
  always_comb begin
    en_nxt = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sum[k] = {1'b0, acc[k]} + ((num[k] > DEN_N) ? {1'b0, DEN_N} : {1'b0, num[k]});
      if (sum[k] >= DEN_W) begin
        acc_nxt[k] = ACC_W'(sum[k] - DEN_W);
        en_nxt[k]  = 1'b1;
      end else begin
        acc_nxt[k] = sum[k][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= ST_LOCKING;
      lock_cnt <= '0;
      en_q     <= '0;
      chan_q   <= '0;
      num_q    <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        acc[k] <= '0;
        num[k] <= NUM_INIT[k*ACC_W +: ACC_W];
      end
    end else begin
      case (state)
        ST_LOCKING: begin
          en_q <= '0;
          for (int unsigned k = 0; k < CHANNELS; k++) acc[k] <= '0;
          if (lock_cnt == LOCK_LAST) begin
            state    <= ST_RUN;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // Out-of-range channel requests are consumed without disturbing the pulse trains.
          if (take && chan_ok) begin
            state  <= ST_RECONF;
            chan_q <= cfg_chan;
            num_q  <= cfg_num;
            en_q   <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) acc[k] <= '0;
          end else begin
            en_q <= en_nxt;
            for (int unsigned k = 0; k < CHANNELS; k++) acc[k] <= acc_nxt[k];
          end
        end
        ST_RECONF: begin
          en_q     <= '0;
          lock_cnt <= '0;
          state    <= ST_LOCKING;
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            acc[k] <= '0;
            if (CHAN_W'(k) == chan_q) num[k] <= num_q;
          end
        end
        default: begin
          state    <= ST_LOCKING;
          lock_cnt <= '0;
          en_q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_synth.sv
// Directed bench for clk_en_synth; three channels so an out-of-range channel code (3) is representable.
module tb_clk_en_synth;

  logic       refclk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [15:0] cfg_num;
  logic [2:0] outclk_en;
  logic       locked;

  int passed = 0;
  int total  = 0;

  clk_en_synth #(
    .CHANNELS(3),
    .ACC_W(16),
    .DEN(120),
    .NUM_INIT({16'd12, 16'd12, 16'd12}),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_num(cfg_num),
    .outclk_en(outclk_en),
    .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step;
    @(posedge refclk);
    #1;
  endtask

  // Expected enables c RUN edges after lock: channel fires when floor(e*c/120) increments.
  function automatic logic [2:0] exp_en(input int n0, input int n1, input int n2, input int c);
    int n [3];
    int e;
    logic [2:0] r;
    n = '{n0, n1, n2};
    r = '0;
    for (int k = 0; k < 3; k++) begin
      e = (n[k] > 120) ? 120 : n[k];
      if (c > 0 && (e * c) / 120 != (e * (c - 1)) / 120) r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_num = '0;
    repeat (3) step();
    total++;
    if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else passed++;
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready); else passed++;
    total++;
    if (outclk_en !== 3'b000) $display("FAIL reset_en: got %b expected 000", outclk_en); else passed++;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      total++;
      if (locked !== (i == 16)) $display("FAIL reset_lock_edge%0d: got %b expected %b", i, locked, (i == 16));
      else passed++;
    end
    total++;
    if (outclk_en !== 3'b000) $display("FAIL first_run_en: got %b expected 000", outclk_en); else passed++;
    for (int c = 1; c <= 40; c++) begin
      step();
      total++;
      if (outclk_en !== ((c % 10 == 0) ? 3'b111 : 3'b000))
        $display("FAIL default_train c=%0d: got %b expected %b", c, outclk_en, (c % 10 == 0) ? 3'b111 : 3'b000);
      else passed++;
    end
  endtask

  task automatic test_reconf_ch1;
    int cnt1;
    int first1;
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_num = 16'd7;
    step();
    cfg_valid = 1'b0;
    total++;
    if ({locked, cfg_ready, outclk_en} !== 5'b00000)
      $display("FAIL reconf_state: got %b expected 00000", {locked, cfg_ready, outclk_en});
    else passed++;
    for (int i = 1; i <= 17; i++) begin
      step();
      total++;
      if (locked !== (i == 17)) $display("FAIL reconf_lock_edge%0d: got %b expected %b", i, locked, (i == 17));
      else passed++;
    end
    cnt1 = 0; first1 = 0;
    for (int c = 1; c <= 240; c++) begin
      step();
      if (outclk_en[1] && first1 == 0) first1 = c;
      if (c <= 120 && outclk_en[1]) cnt1++;
      total++;
      if (outclk_en !== exp_en(12, 7, 12, c))
        $display("FAIL ch1_7_train c=%0d: got %b expected %b", c, outclk_en, exp_en(12, 7, 12, c));
      else passed++;
    end
    total++;
    if (first1 !== 18) $display("FAIL ch1_first_pulse: got %0d expected 18", first1); else passed++;
    total++;
    if (cnt1 !== 7) $display("FAIL ch1_pulse_count: got %0d expected 7", cnt1); else passed++;
  endtask

  task automatic test_num_zero;
    int cnt0;
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_num = 16'd0;
    step();
    cfg_valid = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      total++;
      if (locked !== (i == 17)) $display("FAIL zero_lock_edge%0d: got %b expected %b", i, locked, (i == 17));
      else passed++;
    end
    cnt0 = 0;
    for (int c = 1; c <= 1080; c++) begin
      step();
      if (outclk_en[0]) cnt0++;
      total++;
      if (outclk_en !== exp_en(0, 7, 12, c))
        $display("FAIL zero_train c=%0d: got %b expected %b", c, outclk_en, exp_en(0, 7, 12, c));
      else passed++;
    end
    total++;
    if (cnt0 !== 0) $display("FAIL ch0_zero_count: got %0d expected 0", cnt0); else passed++;
  endtask

  task automatic test_num_full(input int n0);
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_num = 16'(n0);
    step();
    cfg_valid = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      total++;
      if (locked !== (i == 17)) $display("FAIL full%0d_lock_edge%0d: got %b expected %b", n0, i, locked, (i == 17));
      else passed++;
    end
    total++;
    if (outclk_en[0] !== 1'b0) $display("FAIL full%0d_first_run: got %b expected 0", n0, outclk_en[0]); else passed++;
    for (int c = 1; c <= 120; c++) begin
      step();
      total++;
      if (outclk_en !== exp_en(n0, 7, 12, c) || outclk_en[0] !== 1'b1)
        $display("FAIL full%0d_train c=%0d: got %b expected %b", n0, c, outclk_en, exp_en(n0, 7, 12, c));
      else passed++;
    end
  endtask

  task automatic test_invalid_chan;
    for (int c = 1; c <= 120; c++) begin
      if (c == 6) begin
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_num = 16'd50;
        total++;
        if (cfg_ready !== 1'b1) $display("FAIL invalid_ready_before: got %b expected 1", cfg_ready); else passed++;
      end
      step();
      if (c == 6) begin
        cfg_valid = 1'b0;
        total++;
        if ({locked, cfg_ready} !== 2'b11) $display("FAIL invalid_after: got %b expected 11", {locked, cfg_ready});
        else passed++;
      end
      total++;
      if (outclk_en !== exp_en(200, 7, 12, c))
        $display("FAIL invalid_train c=%0d: got %b expected %b", c, outclk_en, exp_en(200, 7, 12, c));
      else passed++;
    end
  endtask

  task automatic test_rst_in_locking;
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_num = 16'd30;
    step();
    cfg_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    total++;
    if ({locked, cfg_ready, outclk_en} !== 5'b00000)
      $display("FAIL rst_locking_state: got %b expected 00000", {locked, cfg_ready, outclk_en});
    else passed++;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      total++;
      if (locked !== (i == 16)) $display("FAIL rst_relock_edge%0d: got %b expected %b", i, locked, (i == 16));
      else passed++;
    end
    for (int c = 1; c <= 120; c++) begin
      step();
      total++;
      if (outclk_en !== exp_en(12, 12, 12, c))
        $display("FAIL rst_revert_train c=%0d: got %b expected %b", c, outclk_en, exp_en(12, 12, 12, c));
      else passed++;
    end
  endtask

  task automatic test_rst_with_cfg;
    rst = 1'b1; cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_num = 16'd0;
    step();
    rst = 1'b0; cfg_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      total++;
      if (locked !== (i == 16)) $display("FAIL rstcfg_lock_edge%0d: got %b expected %b", i, locked, (i == 16));
      else passed++;
    end
    for (int c = 1; c <= 120; c++) begin
      step();
      total++;
      if (outclk_en !== exp_en(12, 12, 12, c))
        $display("FAIL rstcfg_train c=%0d: got %b expected %b", c, outclk_en, exp_en(12, 12, 12, c));
      else passed++;
    end
  endtask

  task automatic test_cfg_held;
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_num = 16'd24;
    step();
    cfg_num = 16'd40;
    for (int i = 1; i <= 17; i++) begin
      step();
      total++;
      if ({locked, cfg_ready} !== ((i == 17) ? 2'b11 : 2'b00))
        $display("FAIL held_lock_edge%0d: got %b expected %b", i, {locked, cfg_ready}, (i == 17) ? 2'b11 : 2'b00);
      else passed++;
    end
    step();
    cfg_valid = 1'b0;
    total++;
    if ({locked, cfg_ready, outclk_en} !== 5'b00000)
      $display("FAIL held_second_transfer: got %b expected 00000", {locked, cfg_ready, outclk_en});
    else passed++;
    for (int i = 1; i <= 17; i++) begin
      step();
      total++;
      if (locked !== (i == 17)) $display("FAIL held_relock_edge%0d: got %b expected %b", i, locked, (i == 17));
      else passed++;
    end
    for (int c = 1; c <= 120; c++) begin
      step();
      total++;
      if (outclk_en !== exp_en(12, 12, 40, c))
        $display("FAIL held_train c=%0d: got %b expected %b", c, outclk_en, exp_en(12, 12, 40, c));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reconf_ch1();
    test_num_zero();
    test_num_full(120);
    test_num_full(200);
    test_invalid_chan();
    test_rst_in_locking();
    test_rst_with_cfg();
    test_cfg_held();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
